mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the memory data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports are named clock and clear_n.
REQ-004 The block SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL have port clear_n, input, 1 bit: asynchronous active-low reset.
REQ-006 For each requester N in {0,1}, the block SHALL have the following ports:
- rN_valid, input, 1 bit: request present.
- rN_address, input, ADDR_WIDTH bits: request address.
- rN_write, input, 1 bit: 1 = write, 0 = read.
- rN_write_data, input, DATA_WIDTH bits: write payload.
- rN_ready, output, 1 bit: request accepted this cycle.
- rN_ack_valid, output, 1 bit: response present.
- rN_ack_error, output, 1 bit: response error flag.
- rN_ack_read_data, output, DATA_WIDTH bits: read data.
- rN_ack_ready, input, 1 bit: requester takes the response.
REQ-007 The block SHALL have the following memory-side ports:
- mem_valid, output, 1 bit: forwarded request present.
- mem_address, output, ADDR_WIDTH bits.
- mem_write, output, 1 bit.
- mem_write_data, output, DATA_WIDTH bits.
- mem_ready, input, 1 bit: memory accepts the request.
- mem_ack_valid, input, 1 bit.
- mem_ack_error, input, 1 bit.
- mem_ack_read_data, input, DATA_WIDTH bits.
- mem_ack_ready, output, 1 bit.

Function
REQ-008 The block SHALL implement the states IDLE, ISSUE and WAIT_ACK, with a registered 1-bit grant and a registered 1-bit priority pointer.
REQ-009 In IDLE with any rN_valid=1, the block SHALL register grant and go to ISSUE next cycle:
- If only one requester is valid, that requester wins.
- If both are valid, the requester equal to the pointer wins.
REQ-010 In IDLE with no valid requester, the block SHALL stay in IDLE and drive mem_valid=0.
REQ-011 In ISSUE, the block SHALL set mem_valid, mem_address, mem_write and mem_write_data combinationally to the granted requester's rN_valid, rN_address, rN_write and rN_write_data.
REQ-012 In ISSUE, the block SHALL set r[grant]_ready = mem_valid & mem_ready; the other requester's ready SHALL be 0.
REQ-013 When ISSUE sees mem_valid & mem_ready, the block SHALL go to WAIT_ACK; when mem_valid=0, it SHALL return to IDLE and leave the pointer unchanged.
REQ-014 In WAIT_ACK, the block SHALL forward the response to the granted requester only:
- mem_ack_ready = r[grant]_ack_ready.
- r[grant]_ack_valid = mem_ack_valid.
- r[grant]_ack_error = mem_ack_error.
- The non-granted requester's ack_valid and ack_error SHALL be 0.
REQ-015 The block SHALL drive both rN_ack_read_data with mem_ack_read_data at all times.
REQ-016 When WAIT_ACK sees mem_ack_valid & mem_ack_ready, the block SHALL go to IDLE and set pointer = ~grant (round robin).
REQ-017 Outside WAIT_ACK, the block SHALL drive mem_ack_ready=0 and all rN_ack_valid=0. A response that arrives early is stalled, not dropped.
REQ-018 The block SHALL allow at most one outstanding memory transaction; no new grant SHALL be made before the response handshake completes.
REQ-019 Latency: a request seen in IDLE at cycle t SHALL appear on mem_valid at t+1. With zero-wait memory, the response SHALL reach the requester at t+2, and IDLE SHALL be re-entered at t+3.
REQ-020 A requester SHALL hold rN_valid and its payload stable until rN_ready; the arbiter does not latch the payload.

Reset
REQ-021 Asserting clear_n=0 SHALL immediately force IDLE, grant=0 and pointer=0.
REQ-022 While clear_n=0, the block SHALL drive all outputs to 0: mem_valid, mem_address, mem_write, mem_write_data, mem_ack_ready, rN_ready, rN_ack_valid and rN_ack_error.
REQ-023 A transaction in flight when reset asserts SHALL be abandoned and not replayed; after release, arbitration SHALL restart from IDLE with r0 preferred.

Verification
REQ-024 Scenario, single write: r0 write of 0xDEADBEEF to 0x100, mem_ready=1, ack on the next cycle -> mem_valid at t+1 with address 0x100, r0_ready at t+1, r0_ack_valid at t+2, IDLE at t+3.
REQ-025 Scenario, contention: r0 and r1 valid continuously -> grants alternate r0, r1, r0, r1 from reset.
REQ-026 Scenario, memory stall: mem_ready=0 for 5 cycles -> stays in ISSUE, r0_ready=0 throughout, accepted on cycle 6.
REQ-027 Scenario, response backpressure: r1_ack_ready=0 for 3 cycles during WAIT_ACK -> mem_ack_ready=0 and r1_ack_valid=1 held; r0_ack_valid stays 0; no new grant.
REQ-028 Scenario, error response: mem_ack_error=1 on an r1 read -> r1_ack_error=1 only, r0_ack_error=0.
REQ-029 Scenario, mid-transaction reset: clear_n pulsed low in WAIT_ACK -> all outputs 0 at once; after release with r1 valid alone, r1 is granted in the second cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter onto a single memory port
// One transaction in flight at a time; the payload is passed through, never latched.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear_n,

  input  logic                  r0_valid,
  input  logic [ADDR_WIDTH-1:0] r0_address,
  input  logic                  r0_write,
  input  logic [DATA_WIDTH-1:0] r0_write_data,
  output logic                  r0_ready,
  output logic                  r0_ack_valid,
  output logic                  r0_ack_error,
  output logic [DATA_WIDTH-1:0] r0_ack_read_data,
  input  logic                  r0_ack_ready,

  input  logic                  r1_valid,
  input  logic [ADDR_WIDTH-1:0] r1_address,
  input  logic                  r1_write,
  input  logic [DATA_WIDTH-1:0] r1_write_data,
  output logic                  r1_ready,
  output logic                  r1_ack_valid,
  output logic                  r1_ack_error,
  output logic [DATA_WIDTH-1:0] r1_ack_read_data,
  input  logic                  r1_ack_ready,

  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_ready,
  input  logic                  mem_ack_valid,
  input  logic                  mem_ack_error,
  input  logic [DATA_WIDTH-1:0] mem_ack_read_data,
  output logic                  mem_ack_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   ptr_q, ptr_d;

  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_write_data;
  logic                  sel_ack_ready;
  logic                  in_issue;
  logic                  in_wait;

  // The granted requester's signals, muxed once and reused below.
  assign sel_valid      = grant_q ? r1_valid      : r0_valid;
  assign sel_address    = grant_q ? r1_address    : r0_address;
  assign sel_write      = grant_q ? r1_write      : r0_write;
  assign sel_write_data = grant_q ? r1_write_data : r0_write_data;
  assign sel_ack_ready  = grant_q ? r1_ack_ready  : r0_ack_ready;

  assign in_issue = (state_q == ISSUE);
  assign in_wait  = (state_q == WAIT_ACK);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (r0_valid | r1_valid) begin
          grant_d = (r0_valid & r1_valid) ? ptr_q : r1_valid;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Priority only rotates once a response has actually been delivered.
        if (mem_ack_valid & sel_ack_ready) begin
          state_d = IDLE;
          ptr_d   = ~grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign mem_valid      = in_issue & sel_valid;
  assign mem_address    = in_issue ? sel_address    : '0;
  assign mem_write      = in_issue & sel_write;
  assign mem_write_data = in_issue ? sel_write_data : '0;

  assign r0_ready = mem_valid & mem_ready & ~grant_q;
  assign r1_ready = mem_valid & mem_ready &  grant_q;

  // Responses arriving before WAIT_ACK see mem_ack_ready=0 and are held off.
  assign mem_ack_ready = in_wait & sel_ack_ready;
  assign r0_ack_valid  = in_wait & ~grant_q & mem_ack_valid;
  assign r1_ack_valid  = in_wait &  grant_q & mem_ack_valid;
  assign r0_ack_error  = in_wait & ~grant_q & mem_ack_error;
  assign r1_ack_error  = in_wait &  grant_q & mem_ack_error;

  assign r0_ack_read_data = mem_ack_read_data;
  assign r1_ack_read_data = mem_ack_read_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Directed scenarios, then randomized traffic checked by a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          clear_n;
  logic          r0_valid, r0_write, r0_ready, r0_ack_valid, r0_ack_error, r0_ack_ready;
  logic [AW-1:0] r0_address;
  logic [DW-1:0] r0_write_data, r0_ack_read_data;
  logic          r1_valid, r1_write, r1_ready, r1_ack_valid, r1_ack_error, r1_ack_ready;
  logic [AW-1:0] r1_address;
  logic [DW-1:0] r1_write_data, r1_ack_read_data;
  logic          mem_valid, mem_write, mem_ready, mem_ack_valid, mem_ack_error, mem_ack_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_ack_read_data;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .clear_n(clear_n),
    .r0_valid(r0_valid), .r0_address(r0_address), .r0_write(r0_write),
    .r0_write_data(r0_write_data), .r0_ready(r0_ready), .r0_ack_valid(r0_ack_valid),
    .r0_ack_error(r0_ack_error), .r0_ack_read_data(r0_ack_read_data), .r0_ack_ready(r0_ack_ready),
    .r1_valid(r1_valid), .r1_address(r1_address), .r1_write(r1_write),
    .r1_write_data(r1_write_data), .r1_ready(r1_ready), .r1_ack_valid(r1_ack_valid),
    .r1_ack_error(r1_ack_error), .r1_ack_read_data(r1_ack_read_data), .r1_ack_ready(r1_ack_ready),
    .mem_valid(mem_valid), .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_ack_valid(mem_ack_valid),
    .mem_ack_error(mem_ack_error), .mem_ack_read_data(mem_ack_read_data), .mem_ack_ready(mem_ack_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    bit            id;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
  } req_t;

  req_t exp_q[$];
  int   phase    = 0;   // 0 arbiter idle, 1 request granted, 2 awaiting response
  bit   ptr      = 1'b0;
  bit   cur      = 1'b0;
  int   done_cnt = 0;

  // Monitor / reference model: samples on the falling edge, inputs change at posedge+1.
  initial begin
    forever begin
      @(negedge clock);
      if (!clear_n) begin
        chk("rst_ctrl", {mem_valid, mem_write, mem_ack_ready, r0_ready, r1_ready,
                         r0_ack_valid, r1_ack_valid, r0_ack_error, r1_ack_error}, 64'd0);
        chk("rst_addr", mem_address, 64'd0);
        chk("rst_wdata", mem_write_data, 64'd0);
        phase = 0;
        ptr   = 1'b0;
        exp_q.delete();
      end else begin
        chk("rdata0", r0_ack_read_data, mem_ack_read_data);
        chk("rdata1", r1_ack_read_data, mem_ack_read_data);
        case (phase)
          0: begin
            chk("idle_out", {mem_valid, r0_ready, r1_ready, r0_ack_valid, r1_ack_valid, mem_ack_ready}, 64'd0);
            if (r0_valid || r1_valid) begin
              req_t e;
              e.id   = (r0_valid && r1_valid) ? ptr : r1_valid;
              e.addr = e.id ? r1_address : r0_address;
              e.wr   = e.id ? r1_write : r0_write;
              e.data = e.id ? r1_write_data : r0_write_data;
              exp_q.push_back(e);
              phase = 1;
            end
          end
          1: begin
            req_t e;
            logic want;
            e = exp_q[0];
            want = e.id ? r1_valid : r0_valid;
            chk("iss_mem_valid", mem_valid, want);
            chk("iss_ackside", {mem_ack_ready, r0_ack_valid, r1_ack_valid}, 64'd0);
            if (!want) begin
              void'(exp_q.pop_front());
              phase = 0;
            end else begin
              chk("iss_addr", mem_address, e.addr);
              chk("iss_write", mem_write, e.wr);
              chk("iss_wdata", mem_write_data, e.data);
              chk("iss_ready_win", e.id ? r1_ready : r0_ready, mem_ready);
              chk("iss_ready_lose", e.id ? r0_ready : r1_ready, 64'd0);
              if (mem_ready) begin
                void'(exp_q.pop_front());
                cur   = e.id;
                phase = 2;
              end
            end
          end
          default: begin
            logic ackr;
            ackr = cur ? r1_ack_ready : r0_ack_ready;
            chk("wt_mem_ack_ready", mem_ack_ready, ackr);
            chk("wt_ack_valid_win", cur ? r1_ack_valid : r0_ack_valid, mem_ack_valid);
            chk("wt_ack_err_win", cur ? r1_ack_error : r0_ack_error, mem_ack_error);
            chk("wt_ack_lose", cur ? {r0_ack_valid, r0_ack_error} : {r1_ack_valid, r1_ack_error}, 64'd0);
            chk("wt_no_grant", {mem_valid, r0_ready, r1_ready}, 64'd0);
            if (mem_ack_valid && ackr) begin
              ptr   = ~cur;
              phase = 0;
              done_cnt++;
            end
          end
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  bit grants[$];
  bit hs0, hs1;

  initial begin
    clear_n = 1'b0;
    {r0_valid, r0_write, r0_ack_ready, r1_valid, r1_write, r1_ack_ready} = '0;
    {r0_address, r1_address, r0_write_data, r1_write_data} = '0;
    {mem_ready, mem_ack_valid, mem_ack_error} = '0;
    mem_ack_read_data = '0;
    @(negedge clock);
    chk("d_rst_mem_valid", mem_valid, 64'd0);
    chk("d_rst_ready", {r0_ready, r1_ready}, 64'd0);
    step(); step();
    clear_n = 1'b1;

    // Single write, zero-wait memory: mem_valid t+1, ack t+2, idle t+3.
    r0_valid = 1; r0_address = 32'h100; r0_write = 1; r0_write_data = 32'hDEADBEEF;
    mem_ready = 1; mem_ack_valid = 1; mem_ack_read_data = 32'h0; r0_ack_ready = 1;
    @(negedge clock);
    chk("d_sw_t0_mem_valid", mem_valid, 64'd0);
    @(negedge clock);
    chk("d_sw_t1_mem_valid", mem_valid, 64'd1);
    chk("d_sw_t1_addr", mem_address, 64'h100);
    chk("d_sw_t1_wdata", mem_write_data, 64'hDEADBEEF);
    chk("d_sw_t1_r0_ready", r0_ready, 64'd1);
    chk("d_sw_t1_early_ack", {r0_ack_valid, mem_ack_ready}, 64'd0);
    step();
    r0_valid = 0;
    @(negedge clock);
    chk("d_sw_t2_ack_valid", r0_ack_valid, 64'd1);
    chk("d_sw_t2_mem_ack_ready", mem_ack_ready, 64'd1);
    step();
    mem_ack_valid = 0;
    @(negedge clock);
    chk("d_sw_t3_idle", {mem_valid, r0_ack_valid, mem_ack_ready}, 64'd0);

    // Contention from reset: grants alternate starting with r0.
    step();
    clear_n = 0;
    step();
    clear_n = 1;
    r0_valid = 1; r0_address = 32'hA0; r0_write = 0;
    r1_valid = 1; r1_address = 32'hB0; r1_write = 1; r1_write_data = 32'h1234;
    mem_ack_valid = 1; r1_ack_ready = 1;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      @(negedge clock);
      if (r0_ready) grants.push_back(1'b0);
      if (r1_ready) grants.push_back(1'b1);
    end
    chk("d_cont_count", grants.size(), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("d_cont_grant%0d", i), (i < grants.size()) ? grants[i] : 1'bx, i % 2);
    step();
    r0_valid = 0; r1_valid = 0; mem_ack_valid = 1;
    step();
    mem_ack_valid = 0;
    step();

    // Memory stall: five ISSUE cycles without mem_ready, accepted on the sixth.
    r0_valid = 1; r0_address = 32'h200; r0_write = 0; mem_ready = 0;
    @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("d_stall_mem_valid", mem_valid, 64'd1);
      chk("d_stall_r0_ready", r0_ready, 64'd0);
    end
    step();
    mem_ready = 1;
    @(negedge clock);
    chk("d_stall_accept", r0_ready, 64'd1);
    step();
    r0_valid = 0; mem_ack_valid = 1; r0_ack_ready = 1;
    @(negedge clock);
    chk("d_stall_ack", r0_ack_valid, 64'd1);
    step();
    mem_ack_valid = 0;

    // Response backpressure and error on an r1 read while r0 waits.
    r1_valid = 1; r1_address = 32'h300; r1_write = 0; r1_ack_ready = 0;
    r0_valid = 1; r0_address = 32'h380; r0_write = 1; r0_write_data = 32'h55;
    mem_ack_valid = 1; mem_ack_error = 1; mem_ack_read_data = 32'hCAFE0001;
    @(negedge clock);
    @(negedge clock);
    chk("d_bp_r1_ready", r1_ready, 64'd1);
    chk("d_bp_r0_ready", r0_ready, 64'd0);
    step();
    r1_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("d_bp_mem_ack_ready", mem_ack_ready, 64'd0);
      chk("d_bp_r1_ack_valid", r1_ack_valid, 64'd1);
      chk("d_bp_r0_ack_valid", r0_ack_valid, 64'd0);
      chk("d_bp_no_grant", {mem_valid, r0_ready}, 64'd0);
    end
    step();
    r1_ack_ready = 1;
    @(negedge clock);
    chk("d_err_r1", r1_ack_error, 64'd1);
    chk("d_err_r0", r0_ack_error, 64'd0);
    chk("d_err_rdata", r1_ack_read_data, 64'hCAFE0001);
    step();
    mem_ack_valid = 0; mem_ack_error = 0;
    @(negedge clock);
    @(negedge clock);
    chk("d_bp_r0_next", r0_ready, 64'd1);

    // Reset while waiting for r0's response, then r1 alone after release.
    step();
    r0_valid = 0; r0_ack_ready = 0; mem_ack_valid = 1;
    @(negedge clock);
    chk("d_mr_in_wait", r0_ack_valid, 64'd1);
    step();
    clear_n = 0;
    r1_valid = 1; r1_address = 32'h400; r1_write = 0;
    #1;
    chk("d_mr_outs", {mem_valid, mem_ack_ready, r0_ready, r1_ready, r0_ack_valid,
                      r1_ack_valid, r0_ack_error, r1_ack_error}, 64'd0);
    step();
    clear_n = 1;
    @(negedge clock);
    chk("d_mr_c1", {mem_valid, r1_ready}, 64'd0);
    @(negedge clock);
    chk("d_mr_c2_r1_ready", r1_ready, 64'd1);
    chk("d_mr_c2_addr", mem_address, 64'h400);
    step();
    r1_valid = 0; r1_ack_ready = 1; mem_ack_valid = 1;
    step();
    mem_ack_valid = 0;
    step();

    // Randomized traffic; requesters hold valid/payload until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      hs0 = r0_valid & r0_ready;
      hs1 = r1_valid & r1_ready;
      step();
      if (!clear_n) clear_n = 1;
      else if ($urandom_range(0, 299) == 0) clear_n = 0;
      if (!r0_valid || hs0) begin
        r0_valid = ($urandom_range(0, 2) != 0);
        r0_address = $urandom; r0_write = $urandom_range(0, 1); r0_write_data = $urandom;
      end
      if (!r1_valid || hs1) begin
        r1_valid = ($urandom_range(0, 2) != 0);
        r1_address = $urandom; r1_write = $urandom_range(0, 1); r1_write_data = $urandom;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_ack_valid = ($urandom_range(0, 2) != 0);
      mem_ack_error = ($urandom_range(0, 4) == 0);
      mem_ack_read_data = $urandom;
      r0_ack_ready = ($urandom_range(0, 3) != 0);
      r1_ack_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    chk("rand_progress", done_cnt > 100, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
